// File: rtl/jtkunio_gfxrom_slots.sv
// ---------------------------------------------------------------------------
// jtkunio_gfxrom_slots : char/scroll/obj ROM slots sharing one SDRAM port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jtkunio_gfxrom_slots #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h48000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] char_addr,
  output logic [31:0] char_data,
  output logic        char_ok,
  input  logic [16:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic [17:0] obj_addr,
  input  logic        obj_cs,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dv,
  input  logic [15:0] sdram_din
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q;
  logic [1:0]  sel_q;
  logic [17:0] lat_addr_q;
  logic [21:0] sdram_addr_q;
  logic [31:0] buf_q;
  logic [31:0] char_data_q, scr_data_q, obj_data_q;
  logic [13:0] char_addr_q;
  logic [16:0] scr_addr_q;
  logic [17:0] obj_addr_q;
  logic        char_vld_q, scr_vld_q, obj_vld_q;

  logic [2:0]  pend;
  logic [2:0]  idx;
  logic        gnt_vld;
  logic [1:0]  gnt_id;
  logic [17:0] gnt_addr;
  logic [21:0] gnt_sdram;

  assign char_ok    = char_vld_q && (char_addr_q == char_addr);
  assign scr_ok     = scr_vld_q  && (scr_addr_q  == scr_addr);
  assign obj_ok     = obj_vld_q  && (obj_addr_q  == obj_addr) && obj_cs;
  assign char_data  = char_data_q;
  assign scr_data   = scr_data_q;
  assign obj_data   = obj_data_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_req  = (state_q == ST_REQ);

  assign pend = {obj_cs & ~obj_ok, ~scr_ok, ~char_ok};

  // Round-robin search: ptr_q is the slot with highest priority this round
  always_comb begin
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = ptr_q;
    for (int i = 0; i < 3; i++) begin
      idx = {1'b0, ptr_q} + 3'(i);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!gnt_vld && pend[idx[1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[1:0];
      end
    end
  end

  always_comb begin
    gnt_addr  = {4'b0, char_addr};
    gnt_sdram = CHAR_OFFSET + {7'b0, char_addr, 1'b0};
    case (gnt_id)
      2'd1: begin
        gnt_addr  = {1'b0, scr_addr};
        gnt_sdram = SCR_OFFSET + {4'b0, scr_addr, 1'b0};
      end
      2'd2: begin
        gnt_addr  = obj_addr;
        gnt_sdram = OBJ_OFFSET + {3'b0, obj_addr, 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (gnt_vld)   state_d = ST_REQ;
      ST_REQ:     if (sdram_ack) state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (sdram_dv)  state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (sdram_dv)  state_d = ST_DONE;
      ST_DONE:                   state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 2'd0;
      sel_q        <= 2'd0;
      lat_addr_q   <= '0;
      sdram_addr_q <= '0;
      buf_q        <= '0;
      char_data_q  <= '0;
      scr_data_q   <= '0;
      obj_data_q   <= '0;
      char_addr_q  <= '0;
      scr_addr_q   <= '0;
      obj_addr_q   <= '0;
      char_vld_q   <= 1'b0;
      scr_vld_q    <= 1'b0;
      obj_vld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && gnt_vld) begin
        sel_q        <= gnt_id;
        lat_addr_q   <= gnt_addr;
        sdram_addr_q <= gnt_sdram;
        ptr_q        <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
      end
      if (state_q == ST_WAIT_LO && sdram_dv) buf_q[15:0]  <= sdram_din;
      if (state_q == ST_WAIT_HI && sdram_dv) buf_q[31:16] <= sdram_din;
      // Fill uses the address latched at grant time, not the live request
      if (state_q == ST_DONE) begin
        case (sel_q)
          2'd0: begin
            char_data_q <= buf_q;
            char_addr_q <= lat_addr_q[13:0];
            char_vld_q  <= 1'b1;
          end
          2'd1: begin
            scr_data_q <= buf_q;
            scr_addr_q <= lat_addr_q[16:0];
            scr_vld_q  <= 1'b1;
          end
          2'd2: begin
            obj_data_q <= buf_q;
            obj_addr_q <= lat_addr_q;
            obj_vld_q  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtkunio_gfxrom_slots.sv
// Bench for jtkunio_gfxrom_slots: SDRAM responder, request-order scoreboard and data reference model.
`default_nettype none

module tb_jtkunio_gfxrom_slots;

  localparam logic [21:0] C_OFF = 22'h00000;
  localparam logic [21:0] S_OFF = 22'h08000;
  localparam logic [21:0] O_OFF = 22'h48000;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] char_addr;
  logic [31:0] char_data;
  logic        char_ok;
  logic [16:0] scr_addr;
  logic [31:0] scr_data;
  logic        scr_ok;
  logic [17:0] obj_addr;
  logic        obj_cs;
  logic [31:0] obj_data;
  logic        obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_dv;
  logic [15:0] sdram_din;

  always #5 clk = ~clk;

  jtkunio_gfxrom_slots dut (
    .clk        (clk),
    .rst        (rst),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .char_ok    (char_ok),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_addr   (obj_addr),
    .obj_cs     (obj_cs),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dv   (sdram_dv),
    .sdram_din  (sdram_din)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          ack_cnt = 0;
  int          dv1_cnt = 0;
  logic [21:0] exp_q[$];
  logic        req_prev = 1'b0;

  // SDRAM content: two fixed words for the first directed case, a hash elsewhere
  function automatic logic [15:0] memf(input logic [21:0] a);
    if (a == 22'h20) return 16'h1234;
    if (a == 22'h21) return 16'hABCD;
    return (a[15:0] * 16'h9E37) ^ {a[21:16], a[9:0]} ^ 16'h5A5A;
  endfunction

  function automatic logic [21:0] map(input logic [21:0] off, input int a);
    return off + 22'(a * 2);
  endfunction

  function automatic logic [31:0] word(input logic [21:0] off, input int a);
    logic [21:0] w;
    w = map(off, a);
    return {memf(w + 22'd1), memf(w)};
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // SDRAM controller model
  initial begin
    sdram_ack = 1'b0;
    sdram_dv  = 1'b0;
    sdram_din = '0;
    forever begin
      logic [21:0] a;
      @(negedge clk);
      if (sdram_req && !rst) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sdram_ack = 1'b1;
        a = sdram_addr;
        @(negedge clk);
        sdram_ack = 1'b0;
        ack_cnt++;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        sdram_dv  = 1'b1;
        sdram_din = memf(a);
        @(negedge clk);
        sdram_dv = 1'b0;
        dv1_cnt++;
        repeat ($urandom_range(2, 3)) @(negedge clk);
        sdram_dv  = 1'b1;
        sdram_din = memf(a + 22'd1);
        @(negedge clk);
        sdram_dv = 1'b0;
      end
    end
  end

  // Monitor: data model on every hit, request order against the scoreboard queue
  always @(negedge clk) begin
    if (!rst) begin
      if (char_ok) check("char_data", char_data, word(C_OFF, int'(char_addr)));
      if (scr_ok)  check("scr_data",  scr_data,  word(S_OFF, int'(scr_addr)));
      if (obj_ok) begin
        check("obj_ok_needs_cs", 32'(obj_cs), 32'd1);
        check("obj_data", obj_data, word(O_OFF, int'(obj_addr)));
      end
      if (sdram_req && !req_prev && exp_q.size() > 0)
        check("sdram_addr", 32'(sdram_addr), 32'(exp_q.pop_front()));
    end
    req_prev = sdram_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (char_ok && scr_ok && (obj_ok || !obj_cs) && exp_q.size() == 0 && !sdram_req) done = 1'b1;
      else tick();
    end
    check(nm, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int          d;
    bit          seen;

    rst = 1'b1; char_addr = 14'h0010; scr_addr = '0; obj_addr = '0; obj_cs = 1'b0;
    repeat (3) tick();
    check("rst_req",       32'(sdram_req),  32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rst_ok",        32'({char_ok, scr_ok, obj_ok}), 32'd0);
    check("rst_data",      char_data | scr_data | obj_data, 32'd0);

    // Reset-state arbiter favours char
    exp_q.push_back(22'h00020);
    exp_q.push_back(map(S_OFF, 0));
    rst = 1'b0;
    settle("t1_settle");
    check("t1_char_data", char_data, 32'hABCD1234);

    // obj_cs low never requests
    obj_addr = 18'h1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3_no_req", 32'({sdram_req, obj_ok}), 32'd0);
    end
    exp_q.push_back(22'h48002);
    obj_cs = 1'b1;
    settle("t3_settle");

    // Simultaneous misses after obj was last served
    char_addr = 14'h0123; scr_addr = 17'h1ABCD; obj_addr = 18'h3FFFF;
    exp_q.push_back(map(C_OFF, 'h123));
    exp_q.push_back(map(S_OFF, 'h1ABCD));
    exp_q.push_back(map(O_OFF, 'h3FFFF));
    settle("t2_round1");
    char_addr = 14'h0124; scr_addr = 17'h1ABCE;
    exp_q.push_back(map(C_OFF, 'h124));
    exp_q.push_back(map(S_OFF, 'h1ABCE));
    settle("t2_round2");

    // Address change while the high word is outstanding
    d = dv1_cnt;
    scr_addr = 17'h5;
    exp_q.push_back(S_OFF + 22'h0A);
    exp_q.push_back(S_OFF + 22'h0C);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (dv1_cnt != d) seen = 1'b1;
    end
    check("t4_first_dv", 32'(seen), 32'd1);
    scr_addr = 17'h6;
    settle("t4_settle");
    check("t4_scr_data", scr_data, word(S_OFF, 6));

    // Reset while waiting for the low word
    d = ack_cnt;
    char_addr = 14'h0200;
    exp_q.push_back(map(C_OFF, 'h200));
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (ack_cnt != d) seen = 1'b1;
    end
    check("t5_ack", 32'(seen), 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("t5_in_reset", 32'({sdram_req, char_ok, scr_ok, obj_ok}), 32'd0);
    end
    exp_q.push_back(map(C_OFF, 'h200));
    exp_q.push_back(map(S_OFF, 6));
    exp_q.push_back(map(O_OFF, 'h3FFFF));
    rst = 1'b0;
    tick();
    check("t5_no_fill", 32'({char_ok, scr_ok, obj_ok}), 32'd0);
    settle("t5_settle");

    // Held hit stays stable while other slots churn
    held = char_data;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) scr_addr = 17'($urandom_range(0, 15));
      if (k % 6 == 0) begin
        obj_addr = 18'($urandom_range(0, 15));
        obj_cs   = 1'($urandom_range(0, 1));
      end
      tick();
      check("t6_char_hit", {char_data[31:1], char_ok}, {held[31:1], 1'b1});
      check("t6_char_lsb", 32'(char_data[0]), 32'(held[0]));
    end

    // Random traffic over small address windows to mix hits and misses
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) char_addr = 14'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) scr_addr  = 17'h1FFF8 + 17'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) obj_addr  = 18'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) obj_cs   = ~obj_cs;
      tick();
    end
    settle("final_settle");
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
